// File: rtl/sipo_frame_rx_pkg.sv
// sipo_pkg: shared types and line-level constants for the serial frame receiver.
//   rx_state_t : receiver FSM state encoding
//   START_BIT  : line level that opens a frame
//   STOP_BIT   : line level that must close a good frame
package sipo_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      STOP = 2'd2
   } rx_state_t;

   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/sipo_frame_rx_if.sv
// sipo_frame_rx_if: serial input side plus parallel valid/ready output side.
//   bit_en, data_in : serial bit strobe and bit value
//   out_ready       : consumer accepts the word when out_valid & out_ready
//   data_out        : assembled word, stable while out_valid
//   out_valid       : word pending
//   frame_err       : one-cycle pulse, stop bit sampled low
//   overrun         : one-cycle pulse, good frame dropped because a word was pending
// master drives the serial side and consumes the word; slave is the receiver.
interface sipo_frame_rx_if #(
   parameter int DATA_W = 8
);
   logic              bit_en;
   logic              data_in;
   logic              out_ready;
   logic [DATA_W-1:0] data_out;
   logic              out_valid;
   logic              frame_err;
   logic              overrun;

   modport master (
      output bit_en, data_in, out_ready,
      input  data_out, out_valid, frame_err, overrun
   );

   modport slave (
      input  bit_en, data_in, out_ready,
      output data_out, out_valid, frame_err, overrun
   );
endinterface

// File: rtl/sipo_frame_rx_shift_reg.sv
// sipo_shift_reg: generic serial-in shift register.
//   clk, reset : clock, asynchronous active-high reset (clears q)
//   shift_en   : shift data_in in on this cycle
//   data_in    : serial bit
//   q          : register contents
// LSB_FIRST=1 shifts right and inserts at the MSB, so the first bit ends at q[0];
// LSB_FIRST=0 shifts left and inserts at the LSB, so the first bit ends at the MSB.
module sipo_shift_reg #(
   parameter int DATA_W    = 8,
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              shift_en,
   input  logic              data_in,
   output logic [DATA_W-1:0] q
);

   logic [DATA_W-1:0] q_q;
   logic [DATA_W-1:0] q_d;
   logic [DATA_W-1:0] shifted;

   generate
      if (DATA_W == 1) begin : g_single
         assign shifted = data_in;
      end else if (LSB_FIRST) begin : g_lsb_first
         assign shifted = {data_in, q_q[DATA_W-1:1]};
      end else begin : g_msb_first
         assign shifted = {q_q[DATA_W-2:0], data_in};
      end
   endgenerate

   always_comb begin
      q_d = q_q;
      if (shift_en) q_d = shifted;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) q_q <= '0;
      else       q_q <= q_d;
   end

   assign q = q_q;

endmodule

// File: rtl/sipo_frame_rx.sv
// sipo_frame_rx: serial frame receiver (start 0, DATA_W data bits, stop 1) with a
// valid/ready parallel output, framing-error and overrun pulses.
//   clk, reset : clock, asynchronous active-high reset (back to IDLE, outputs 0)
//   rx         : slave side of sipo_frame_rx_if (DATA_W must match)
//
// state | meaning
// IDLE  | line idle, waiting for a start bit on bit_en
// DATA  | shifting in data bits, cnt_q = bits received so far
// STOP  | all data bits in, next bit_en samples the stop bit
module sipo_frame_rx
   import sipo_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic            clk,
   input  logic            reset,
   sipo_frame_rx_if.slave  rx
);

   localparam int               CNT_W    = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);

   rx_state_t         state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] data_out_q, data_out_d;
   logic              out_valid_q, out_valid_d;
   logic              frame_err_q, frame_err_d;
   logic              overrun_q, overrun_d;
   logic [DATA_W-1:0] shift_q;
   logic              shift_en;

   assign shift_en = rx.bit_en && (state_q == DATA);

   sipo_shift_reg #(
      .DATA_W    (DATA_W),
      .LSB_FIRST (LSB_FIRST)
   ) u_shift_reg (
      .clk      (clk),
      .reset    (reset),
      .shift_en (shift_en),
      .data_in  (rx.data_in),
      .q        (shift_q)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      data_out_d  = data_out_q;
      // A pending word is consumed on any accept cycle; a load below overrides.
      out_valid_d = out_valid_q && !rx.out_ready;
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;
      if (rx.bit_en) begin
         case (state_q)
            IDLE: begin
               if (rx.data_in == START_BIT) begin
                  state_d = DATA;
                  cnt_d   = '0;
               end
            end
            DATA: begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == LAST_IDX) state_d = STOP;
            end
            STOP: begin
               state_d = IDLE;
               if (rx.data_in == STOP_BIT) begin
                  if (!out_valid_q || rx.out_ready) begin
                     data_out_d  = shift_q;
                     out_valid_d = 1'b1;
                  end else begin
                     overrun_d = 1'b1;
                  end
               end else begin
                  frame_err_d = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         data_out_q  <= '0;
         out_valid_q <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         data_out_q  <= data_out_d;
         out_valid_q <= out_valid_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

   assign rx.data_out  = data_out_q;
   assign rx.out_valid = out_valid_q;
   assign rx.frame_err = frame_err_q;
   assign rx.overrun   = overrun_q;

endmodule
